// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the board LED control blocks: state encoding,
// the all-off LED value and the maximum number of LED requesters.
package led_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } led_state_t;

  localparam logic [7:0] LED_ALL_OFF = 8'hFF;
  localparam int         MAX_REQ     = 4;

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
// Shared by board-status blocks that need a slow human-visible time base.
module led_tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Count 0..TICK_DIV-1 and wrap, independent of any consumer state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the active-low LED bank. Each grant latches the
// winner's pattern and holds it for HOLD_TICKS prescaled ticks; at expiry a
// waiting requester is granted back-to-back, otherwise the bank goes dark.
module led_bank_arbiter
  import led_ctrl_pkg::*;
#(
  parameter int         NREQ       = 4,
  parameter int         TICK_DIV   = 25000000,
  parameter int         HOLD_TICKS = 4,
  parameter logic [7:0] IDLE_PAT   = LED_ALL_OFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] pat,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [1:0]        owner,
  output logic [7:0]        led
);

  localparam int HW = $clog2(HOLD_TICKS + 1);

  led_state_t              r_state;
  led_state_t              w_state_nxt;
  logic [7:0]              r_led;
  logic [7:0]              w_led_nxt;
  logic [NREQ-1:0]         r_gnt;
  logic [NREQ-1:0]         w_gnt_nxt;
  logic                    r_busy;
  logic                    w_busy_nxt;
  logic [1:0]              r_owner;
  logic [1:0]              w_owner_nxt;
  logic [HW-1:0]           r_hold;
  logic [HW-1:0]           w_hold_nxt;
  logic                    w_tick;
  logic                    w_any;
  logic                    w_grant;
  logic [2:0]              w_pick;
  logic [1:0]              w_win;
  logic [MAX_REQ-1:0]      w_req_ext;
  logic [8*MAX_REQ-1:0]    w_pat_ext;

  // Search owner+1, owner+2, ... wrapping modulo NREQ (not modulo 4), so the
  // requester just served is considered last. Returns {found, index}.
  function automatic logic [2:0] pick_rr(input logic [1:0]         cur,
                                         input logic [MAX_REQ-1:0] rq);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = 2'((int'(cur) + k) % NREQ);
      if (!found && rq[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // Pad to the widest configuration so indexing by a 2-bit owner is uniform.
  assign w_req_ext = MAX_REQ'(req);
  assign w_pat_ext = (8*MAX_REQ)'(pat);
  assign w_any     = |req;
  assign w_pick    = pick_rr(r_owner, w_req_ext);
  assign w_win     = w_pick[1:0];

  // Next-state and next-output decision; gnt is a pulse so it defaults low.
  always_comb begin
    w_state_nxt = r_state;
    w_led_nxt   = r_led;
    w_gnt_nxt   = '0;
    w_busy_nxt  = r_busy;
    w_owner_nxt = r_owner;
    w_hold_nxt  = r_hold;
    w_grant     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant = 1'b1;
        end
      end
      ST_SHOW: begin
        // Requests are only looked at on the expiring tick.
        if (w_tick) begin
          if (r_hold != HW'(1)) begin
            w_hold_nxt = r_hold - HW'(1);
          end else if (w_any) begin
            w_grant = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_led_nxt   = IDLE_PAT;
            w_busy_nxt  = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_led_nxt   = IDLE_PAT;
        w_busy_nxt  = 1'b0;
      end
    endcase
    if (w_grant) begin
      w_gnt_nxt   = NREQ'(1) << w_win;
      w_owner_nxt = w_win;
      w_led_nxt   = w_pat_ext[{w_win, 3'b000} +: 8];
      w_busy_nxt  = 1'b1;
      w_hold_nxt  = HW'(HOLD_TICKS);
      w_state_nxt = ST_SHOW;
    end
  end

  // State and output registers; owner resets to NREQ-1 so requester 0 goes first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_led   <= IDLE_PAT;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_owner <= 2'(NREQ - 1);
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_led   <= w_led_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= w_busy_nxt;
      r_owner <= w_owner_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign gnt   = r_gnt;
  assign busy  = r_busy;
  assign owner = r_owner;
  assign led   = r_led;

endmodule
